irq_encoder32: RTL

- 32-source interrupt request encoder. It is the encode-side counterpart of the core's 5-to-32 one-hot decoders: it collapses 32 request lines into a 5-bit source ID.
- It captures rising edges on the request lines into a pending register and applies a software mask.
- It presents the highest-priority pending source as a registered ID with a valid/ack handshake to the CPU control unit.
- Priority: bit 0 is highest. Source i maps to ID i, so decoding the ID reproduces bit i.

---
 rtl/irq_encoder32.sv | 100 ++++++++++
 1 files changed

// File: rtl/irq_encoder32.sv
// irq_encoder32: 32-source edge-captured interrupt encoder.
// Lowest pending+enabled index is presented as a registered ID.
module irq_encoder32 #(
  parameter int NUM_SRC = 32,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_q,
  output logic [NUM_SRC-1:0] pending_q,
  output logic               req_valid,
  output logic [ID_W-1:0]    req_id,
  input  logic               req_ack
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] mask_d;
  logic               req_valid_q, req_valid_d;
  logic [ID_W-1:0]    req_id_q, req_id_d;
  logic [NUM_SRC-1:0] irq_edge;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    win;

  assign irq_edge  = irq_in & ~irq_prev_q;
  assign elig      = pending_q & mask_q;
  assign req_valid = req_valid_q;
  assign req_id    = req_id_q;

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = ID_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    clr         = '0;
    unique case (state_q)
      IDLE: begin
        if (en && (|elig)) begin
          req_id_d    = win;
          req_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (req_ack) begin
          clr[req_id_q] = 1'b1;
          req_valid_d   = 1'b0;
          state_d       = HOLDOFF;
        end
      end
      HOLDOFF: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // A new edge on the acked source outranks its clear.
  assign pending_d = (pending_q & ~clr) | irq_edge;
  assign mask_d    = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_prev_q  <= '1;
      pending_q   <= '0;
      mask_q      <= '0;
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= irq_in;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
    end
  end

endmodule
